// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, flit id bits,
// crossbar idle code and the output scheduler state type.
package noc_pkg;

   localparam int NPORTS = 5;

   localparam logic [2:0] PORT_L = 3'd0;
   localparam logic [2:0] PORT_N = 3'd1;
   localparam logic [2:0] PORT_E = 3'd2;
   localparam logic [2:0] PORT_W = 3'd3;
   localparam logic [2:0] PORT_S = 3'd4;

   localparam int FLIT_HDR_BIT  = 0;
   localparam int FLIT_BODY_BIT = 1;
   localparam int FLIT_TAIL_BIT = 2;

   localparam logic [2:0] XBAR_IDLE = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      ABORT
   } sched_state_t;

   // Round-robin successor, wrapping S back to L.
   function automatic logic [2:0] next_port(input logic [2:0] p);
      return (p >= PORT_S) ? PORT_L : p + 3'd1;
   endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first eligible input
// at or after rr_ptr, wrapping S -> L.
module rr_pick5
   import noc_pkg::*;
(
   input  logic [NPORTS-1:0] eligible,
   input  logic [2:0]        rr_ptr,
   output logic [2:0]        pick,
   output logic              any
);

   logic [2:0]          base;
   logic [2*NPORTS-1:0] dbl;
   logic [NPORTS-1:0]   rot;
   logic [2:0]          off;
   logic [3:0]          sum;

   always_comb begin
      base = (rr_ptr > PORT_S) ? PORT_L : rr_ptr;
      dbl  = {eligible, eligible} >> base;
      rot  = dbl[NPORTS-1:0];
      off  = 3'd0;
      priority case (1'b1)
         rot[0]:  off = 3'd0;
         rot[1]:  off = 3'd1;
         rot[2]:  off = 3'd2;
         rot[3]:  off = 3'd3;
         rot[4]:  off = 3'd4;
         default: off = 3'd0;
      endcase
      sum = {1'b0, base} + {1'b0, off};
      any = |eligible;
      if (!any)
         pick = XBAR_IDLE;
      else if (sum >= 4'(NPORTS))
         pick = 3'(sum - 4'(NPORTS));
      else
         pick = sum[2:0];
   end

endmodule

// File: rtl/packet_output_scheduler.sv
// Output-port scheduler: round-robin wormhole grant, credit
// metering toward the downstream buffer, stall watchdog.
module packet_output_scheduler
   import noc_pkg::*;
#(
   parameter  int CREDITS = 4,
   parameter  int TIMEOUT = 256,
   localparam int CW      = $clog2(CREDITS + 1),
   localparam int SW      = $clog2(TIMEOUT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NPORTS-1:0]     req,
   input  logic [NPORTS-1:0]     flit_valid,
   input  logic [3*NPORTS-1:0]   flit_id,
   input  logic                  credit_return,
   output logic [NPORTS-1:0]     grant,
   output logic [2:0]            xbar_sel,
   output logic                  out_valid,
   output logic [NPORTS-1:0]     pop,
   output logic [CW-1:0]         credit_count,
   output logic                  timeout_abort,
   output logic                  credit_err
);

   localparam logic [CW-1:0] CRED_MAX    = CW'(CREDITS);
   // Counter value whose increment would reach TIMEOUT-1.
   localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT - 2);

   sched_state_t      state;
   logic [2:0]        rr_ptr;
   logic [SW-1:0]     stall_cnt;
   logic [NPORTS-1:0] eligible;
   logic [2:0]        pick;
   logic              any;
   logic [2:0]        own_id;
   logic              tail;

   always_comb begin
      eligible = '0;
      own_id   = '0;
      for (int i = 0; i < NPORTS; i++) begin
         eligible[i] = req[i] & flit_valid[i]
                     & flit_id[3*i + FLIT_HDR_BIT];
         if (grant[i])
            own_id = own_id | flit_id[3*i +: 3];
      end
      tail = own_id[FLIT_TAIL_BIT];
   end

   rr_pick5 u_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .pick     (pick),
      .any      (any)
   );

   assign out_valid = (state == ACTIVE)
                    && |(grant & flit_valid)
                    && (credit_count != '0);
   assign pop           = grant & {NPORTS{out_valid}};
   assign timeout_abort = (state == ABORT);

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_count <= CRED_MAX;
         credit_err   <= 1'b0;
      end else begin
         if (credit_return && credit_count == CRED_MAX)
            credit_err <= 1'b1;
         if (out_valid && !credit_return)
            credit_count <= credit_count - 1'b1;
         else if (!out_valid && credit_return
                  && credit_count != CRED_MAX)
            credit_count <= credit_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         xbar_sel  <= XBAR_IDLE;
         rr_ptr    <= PORT_L;
         stall_cnt <= '0;
      end else begin
         case (state)
            ACTIVE: begin
               if (out_valid) begin
                  stall_cnt <= '0;
                  if (tail) begin
                     state    <= IDLE;
                     grant    <= '0;
                     xbar_sel <= XBAR_IDLE;
                     rr_ptr   <= next_port(xbar_sel);
                  end
               end else if (stall_cnt == STALL_LIMIT) begin
                  state     <= ABORT;
                  grant     <= '0;
                  xbar_sel  <= XBAR_IDLE;
                  rr_ptr    <= next_port(xbar_sel);
                  stall_cnt <= '0;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            ABORT: begin
               state <= IDLE;
            end
            default: begin
               // Illegal encodings recover through the idle path.
               state <= any ? ACTIVE : IDLE;
               if (any) begin
                  grant     <= NPORTS'(1) << pick;
                  xbar_sel  <= pick;
                  stall_cnt <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_packet_output_scheduler.sv
// Bench for packet_output_scheduler: vector table, directed
// corner sequences, then random traffic against a model.
module tb_packet_output_scheduler;
   import noc_pkg::*;

   localparam int CRED = 4;
   localparam int TO   = 8;
   localparam logic [2:0] H  = 3'b001;
   localparam logic [2:0] B  = 3'b010;
   localparam logic [2:0] T  = 3'b100;
   localparam logic [2:0] HT = 3'b101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  req = '0;
   logic [4:0]  flit_valid = '0;
   logic [14:0] flit_id = '0;
   logic        credit_return = 1'b0;
   logic [4:0]  grant;
   logic [2:0]  xbar_sel;
   logic        out_valid;
   logic [4:0]  pop;
   logic [2:0]  credit_count;
   logic        timeout_abort;
   logic        credit_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   packet_output_scheduler #(
      .CREDITS (CRED),
      .TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .flit_valid    (flit_valid),
      .flit_id       (flit_id),
      .credit_return (credit_return),
      .grant         (grant),
      .xbar_sel      (xbar_sel),
      .out_valid     (out_valid),
      .pop           (pop),
      .credit_count  (credit_count),
      .timeout_abort (timeout_abort),
      .credit_err    (credit_err)
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] fid_of(input int p,
                                          input logic [2:0] id);
      return 15'(id) << (3 * p);
   endfunction

   function automatic logic [18:0] dut_out();
      return {grant, xbar_sel, out_valid, pop,
              credit_count, timeout_abort, credit_err};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      flit_valid = '0;
      flit_id = '0;
      credit_return = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [4:0]  req;
      logic [4:0]  fv;
      logic [14:0] fid;
      logic        ret;
      logic [4:0]  eg;
      logic [2:0]  ex;
      logic        eov;
      logic [2:0]  ecc;
      logic        eerr;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(
      input logic [4:0] r, input logic [4:0] v,
      input logic [14:0] f, input logic c,
      input logic [4:0] eg, input logic [2:0] ex,
      input logic eov, input logic [2:0] ecc, input logic eerr);
      vec_t t;
      t.req = r; t.fv = v; t.fid = f; t.ret = c;
      t.eg = eg; t.ex = ex; t.eov = eov;
      t.ecc = ecc; t.eerr = eerr;
      return t;
   endfunction

   // Reference model: who owns the link, idle cycles since the
   // last transfer/grant, credits as a plain saturating integer.
   int m_owner;
   int m_ptr;
   int m_cred;
   int m_stall;
   bit m_abort;
   bit m_err;

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_cred = CRED;
      m_stall = 0; m_abort = 0; m_err = 0;
   endtask

   function automatic bit model_ov();
      return m_owner >= 0 && flit_valid[m_owner] && m_cred > 0;
   endfunction

   function automatic logic [18:0] model_exp();
      logic [4:0] g;
      logic [2:0] x;
      logic       ov;
      g  = (m_owner >= 0) ? 5'(1 << m_owner) : 5'd0;
      x  = (m_owner >= 0) ? 3'(m_owner) : 3'd7;
      ov = model_ov();
      return {g, x, ov, g & {5{ov}}, 3'(m_cred), m_abort, m_err};
   endfunction

   task automatic model_step();
      bit ov;
      bit tl;
      int p;
      ov = model_ov();
      tl = (m_owner >= 0) ? flit_id[3*m_owner + 2] : 1'b0;
      if (credit_return && m_cred == CRED) m_err = 1;
      m_cred = m_cred - int'(ov) + int'(credit_return);
      if (m_cred > CRED) m_cred = CRED;
      if (m_abort) begin
         m_abort = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 5; k++) begin
            p = (m_ptr + k) % 5;
            if (m_owner < 0 && req[p] && flit_valid[p]
                && flit_id[3*p]) begin
               m_owner = p;
               m_stall = 0;
            end
         end
      end else if (ov) begin
         m_stall = 0;
         if (tl) begin
            m_ptr = (m_owner + 1) % 5;
            m_owner = -1;
         end
      end else begin
         m_stall++;
         if (m_stall == TO - 1) begin
            m_abort = 1;
            m_ptr = (m_owner + 1) % 5;
            m_owner = -1;
         end
      end
   endtask

   initial begin
      int n;
      int dly;
      bit seen;
      logic [18:0] exp_v;

      tbl[0]  = mk(0, 0, 0, 0, 5'b00000, 7, 0, 4, 0);
      tbl[1]  = mk(0, 0, 0, 0, 5'b00000, 7, 0, 4, 0);
      tbl[2]  = mk(0, 0, 0, 0, 5'b00000, 7, 0, 4, 0);
      tbl[3]  = mk(5'b01010, 5'b01010, fid_of(1,H)|fid_of(3,H), 0,
                   5'b00000, 7, 0, 4, 0);
      tbl[4]  = mk(5'b01010, 5'b01010, fid_of(1,H)|fid_of(3,H), 0,
                   5'b00010, 1, 1, 4, 0);
      tbl[5]  = mk(5'b01010, 5'b01010, fid_of(1,B)|fid_of(3,H), 0,
                   5'b00010, 1, 1, 3, 0);
      tbl[6]  = mk(5'b01010, 5'b01010, fid_of(1,T)|fid_of(3,H), 1,
                   5'b00010, 1, 1, 2, 0);
      tbl[7]  = mk(5'b01000, 5'b01000, fid_of(3,H), 0,
                   5'b00000, 7, 0, 2, 0);
      tbl[8]  = mk(5'b01000, 5'b01000, fid_of(3,HT), 0,
                   5'b01000, 3, 1, 2, 0);
      tbl[9]  = mk(5'b10001, 5'b10001, fid_of(0,HT)|fid_of(4,H), 0,
                   5'b00000, 7, 0, 1, 0);
      tbl[10] = mk(5'b10001, 5'b10001, fid_of(0,HT)|fid_of(4,H), 0,
                   5'b10000, 4, 1, 1, 0);
      tbl[11] = mk(5'b10001, 5'b10001, fid_of(0,HT)|fid_of(4,B), 0,
                   5'b10000, 4, 0, 0, 0);
      tbl[12] = mk(5'b10001, 5'b10001, fid_of(0,HT)|fid_of(4,B), 1,
                   5'b10000, 4, 0, 0, 0);
      tbl[13] = mk(5'b10001, 5'b10001, fid_of(0,HT)|fid_of(4,T), 0,
                   5'b10000, 4, 1, 1, 0);
      tbl[14] = mk(5'b00001, 5'b00001, fid_of(0,HT), 0,
                   5'b00000, 7, 0, 0, 0);
      tbl[15] = mk(5'b00001, 5'b00001, fid_of(0,HT), 1,
                   5'b00001, 0, 0, 0, 0);
      tbl[16] = mk(5'b00001, 5'b00001, fid_of(0,HT), 1,
                   5'b00001, 0, 1, 1, 0);
      tbl[17] = mk(0, 0, 0, 1, 5'b00000, 7, 0, 1, 0);
      tbl[18] = mk(0, 0, 0, 1, 5'b00000, 7, 0, 2, 0);
      tbl[19] = mk(0, 0, 0, 1, 5'b00000, 7, 0, 3, 0);
      tbl[20] = mk(0, 0, 0, 1, 5'b00000, 7, 0, 4, 0);
      tbl[21] = mk(0, 0, 0, 0, 5'b00000, 7, 0, 4, 1);

      // Vector table: arbitration order, credits, saturation.
      do_reset();
      for (int i = 0; i < 22; i++) begin
         req = tbl[i].req;
         flit_valid = tbl[i].fv;
         flit_id = tbl[i].fid;
         credit_return = tbl[i].ret;
         @(negedge clk);
         exp_v = {tbl[i].eg, tbl[i].ex, tbl[i].eov,
                  tbl[i].eg & {5{tbl[i].eov}}, tbl[i].ecc,
                  1'b0, tbl[i].eerr};
         check($sformatf("vec%0d", i), 32'(dut_out()), 32'(exp_v));
         next_cycle();
      end

      // Credit starvation: six queued flits, only four fit.
      do_reset();
      req = 5'b00001; flit_valid = 5'b00001;
      flit_id = fid_of(0, H);
      n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (pop[0]) n++;
         next_cycle();
         if (n > 0) flit_id = fid_of(0, B);
      end
      @(negedge clk);
      check("cr_xfers", 32'(n), 32'd4);
      check("cr_zero", 32'(credit_count), 32'd0);
      check("cr_hold", 32'(out_valid), 32'd0);
      next_cycle();
      credit_return = 1'b1;
      @(negedge clk);
      check("cr_ret_cycle", 32'(out_valid), 32'd0);
      next_cycle();
      credit_return = 1'b0;
      @(negedge clk);
      check("cr_one", 32'(pop), 32'h01);
      next_cycle();
      @(negedge clk);
      check("cr_after", 32'(out_valid), 32'd0);
      check("cr_after_cnt", 32'(credit_count), 32'd0);

      // Watchdog: E sends its header then goes quiet.
      do_reset();
      req = 5'b00100; flit_valid = 5'b00100;
      flit_id = fid_of(2, H);
      @(negedge clk);
      check("wd_idle", 32'(grant), 32'd0);
      next_cycle();
      @(negedge clk);
      check("wd_hdr", 32'(pop), 32'h04);
      next_cycle();
      req = '0; flit_valid = '0; flit_id = '0;
      dly = 0;
      seen = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         if (timeout_abort) begin
            seen = 1;
            dly = k;
            check("wd_grant", 32'(grant), 32'd0);
            check("wd_xbar", 32'(xbar_sel), 32'd7);
         end
         next_cycle();
      end
      check("wd_delay", 32'(dly), 32'd8);
      req = 5'b01101; flit_valid = 5'b01101;
      flit_id = fid_of(0,H) | fid_of(2,H) | fid_of(3,H);
      @(negedge clk);
      check("wd_pulse_end", 32'(timeout_abort), 32'd0);
      check("wd_idle2", 32'(grant), 32'd0);
      next_cycle();
      @(negedge clk);
      check("wd_rr_next", 32'(grant), 32'h08);

      // Reset in the middle of an L packet.
      do_reset();
      req = 5'b00001; flit_valid = 5'b00001;
      flit_id = fid_of(0, H);
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      check("mr_hdr", 32'(pop), 32'h01);
      next_cycle();
      flit_id = fid_of(0, B);
      @(negedge clk);
      next_cycle();
      rst = 1'b1;
      req = 5'b10000; flit_valid = 5'b10000;
      flit_id = fid_of(4, H);
      @(negedge clk);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("mr_grant", 32'(grant), 32'd0);
      check("mr_xbar", 32'(xbar_sel), 32'd7);
      check("mr_cred", 32'(credit_count), 32'd4);
      check("mr_ov", 32'(out_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check("mr_s_grant", 32'(grant), 32'h10);
      check("mr_s_xbar", 32'(xbar_sel), 32'd4);

      // Random traffic against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         logic [2:0] ids[5];
         ids[0] = H; ids[1] = B; ids[2] = T; ids[3] = HT; ids[4] = B;
         rst = ($urandom_range(0, 399) == 0);
         req = 5'($urandom);
         for (int i = 0; i < 5; i++) begin
            flit_valid[i] = ($urandom_range(0, 3) != 0);
            flit_id[3*i +: 3] = ids[$urandom_range(0, 4)];
         end
         credit_return = (m_cred < CRED)
                      && ($urandom_range(0, 2) == 0);
         @(negedge clk);
         check("rand", 32'(dut_out()), 32'(model_exp()));
         if (rst) model_reset();
         else model_step();
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
